udp_header_rx: RTL and testbench

//   Downstream stage of the IPv4 header receiver in the byte-serial RX path. Starts on the
//   IP-header-done pulse, parses the 8-byte UDP header and checks destination port and

---
 rtl/udp_header_rx.sv | 187 ++++++++++++++++++
 tb/tb_udp_header_rx.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_header_rx.sv
// ---------------------------------------------------------------------------
// udp_header_rx
//   Downstream stage of the IPv4 header receiver on the byte-serial RX path.
//   Starts on the IP-header-done pulse and parses the 8-byte UDP header
//   (big-endian). It checks the length field and, optionally, the destination
//   port. For an accepted datagram it forwards exactly (udp_len - 8) payload
//   bytes with valid/last. Any trailing bytes (padding/FCS) are discarded
//   until data_valid drops.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   data_in, data_valid      RX byte stream; data_valid spans the whole frame
//   ip_header_done           pulse; UDP byte 0 is on data_in this cycle
//   ip_header_valid          pulse one cycle after ip_header_done if IP is OK
//   udp_local_port           port accepted when PORT_CHECK_EN != 0
//   udp_src_port/dst_port/len/checksum   captured header fields, held
//   udp_header_done          pulse: header accepted, payload follows
//   payload_data/valid/last  forwarded payload, one cycle after data_in
//   udp_error                pulse: datagram rejected (bad length) or truncated
// ---------------------------------------------------------------------------
module udp_header_rx #(
   parameter int          PORT_CHECK_EN = 1,
   parameter logic [15:0] MAX_UDP_LEN   = 16'd1480
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [7:0]  data_in,
   input  logic        data_valid,
   input  logic        ip_header_done,
   input  logic        ip_header_valid,
   input  logic [15:0] udp_local_port,
   output logic [15:0] udp_src_port,
   output logic [15:0] udp_dst_port,
   output logic [15:0] udp_len,
   output logic [15:0] udp_checksum,
   output logic        udp_header_done,
   output logic [7:0]  payload_data,
   output logic        payload_valid,
   output logic        payload_last,
   output logic        udp_error
);

   typedef enum logic [2:0] {
      IDLE,
      SRC_PORT,
      DST_PORT,
      LENGTH,
      CHECKSUM,
      PAYLOAD,
      DROP
   } state_t;

   state_t      state;
   logic        byte_cnt;   // selects the high (0) or low (1) byte of a 2-byte field
   logic [15:0] remaining;  // payload bytes still to forward

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state           <= IDLE;
         byte_cnt        <= 1'b0;
         remaining       <= '0;
         udp_src_port    <= '0;
         udp_dst_port    <= '0;
         udp_len         <= '0;
         udp_checksum    <= '0;
         udp_header_done <= 1'b0;
         payload_data    <= '0;
         payload_valid   <= 1'b0;
         payload_last    <= 1'b0;
         udp_error       <= 1'b0;
      end else begin
         udp_header_done <= 1'b0;
         payload_valid   <= 1'b0;
         payload_last    <= 1'b0;
         udp_error       <= 1'b0;

         case (state)
            IDLE: begin
               if (ip_header_done && data_valid) begin
                  udp_src_port[15:8] <= data_in;
                  byte_cnt           <= 1'b0;
                  state              <= SRC_PORT;
               end
            end

            // A frame ending inside the header counts as truncation.
            // That check takes precedence over the IP-valid check.
            SRC_PORT: begin
               if (!data_valid) begin
                  udp_error <= 1'b1;
                  state     <= IDLE;
               end else if (!ip_header_valid) begin
                  state <= DROP;
               end else begin
                  udp_src_port[7:0] <= data_in;
                  byte_cnt          <= 1'b0;
                  state             <= DST_PORT;
               end
            end

            DST_PORT: begin
               if (!data_valid) begin
                  udp_error <= 1'b1;
                  state     <= IDLE;
               end else if (!byte_cnt) begin
                  udp_dst_port[15:8] <= data_in;
                  byte_cnt           <= 1'b1;
               end else begin
                  udp_dst_port[7:0] <= data_in;
                  byte_cnt          <= 1'b0;
                  state             <= LENGTH;
               end
            end

            LENGTH: begin
               if (!data_valid) begin
                  udp_error <= 1'b1;
                  state     <= IDLE;
               end else if (!byte_cnt) begin
                  udp_len[15:8] <= data_in;
                  byte_cnt      <= 1'b1;
               end else begin
                  udp_len[7:0] <= data_in;
                  byte_cnt     <= 1'b0;
                  state        <= CHECKSUM;
               end
            end

            // The accept/reject decision is made on the final header byte.
            // By then udp_len and udp_dst_port hold their complete values.
            CHECKSUM: begin
               if (!data_valid) begin
                  udp_error <= 1'b1;
                  state     <= IDLE;
               end else if (!byte_cnt) begin
                  udp_checksum[15:8] <= data_in;
                  byte_cnt           <= 1'b1;
               end else begin
                  udp_checksum[7:0] <= data_in;
                  byte_cnt          <= 1'b0;
                  if ((udp_len < 16'd8) || (udp_len > MAX_UDP_LEN)) begin
                     udp_error <= 1'b1;
                     state     <= DROP;
                  end else if ((PORT_CHECK_EN != 0) && (udp_dst_port != udp_local_port)) begin
                     state <= DROP;
                  end else begin
                     udp_header_done <= 1'b1;
                     if (udp_len == 16'd8) begin
                        state <= DROP;
                     end else begin
                        remaining <= udp_len - 16'd8;
                        state     <= PAYLOAD;
                     end
                  end
               end
            end

            // The FSM leaves PAYLOAD on the last byte, so remaining is
            // always non-zero here. A drop of data_valid is therefore a
            // truncation.
            PAYLOAD: begin
               if (!data_valid) begin
                  udp_error <= 1'b1;
                  state     <= IDLE;
               end else begin
                  payload_data  <= data_in;
                  payload_valid <= 1'b1;
                  remaining     <= remaining - 16'd1;
                  if (remaining == 16'd1) begin
                     payload_last <= 1'b1;
                     state        <= DROP;
                  end
               end
            end

            DROP: begin
               if (!data_valid) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_header_rx.sv
module tb_udp_header_rx;

   logic        aclk;
   logic        aresetn;
   logic [7:0]  data_in;
   logic        data_valid;
   logic        ip_header_done;
   logic        ip_header_valid;
   logic [15:0] udp_local_port;

   logic [15:0] udp_src_port, udp_dst_port, udp_len, udp_checksum;
   logic        udp_header_done, payload_valid, payload_last, udp_error;
   logic [7:0]  payload_data;

   // Second instance: port check disabled, fed the same stream
   logic [15:0] a_src, a_dst, a_len, a_cks;
   logic        a_hd, a_pv, a_pl, a_err;
   logic [7:0]  a_pd;

   udp_header_rx #(.PORT_CHECK_EN(1), .MAX_UDP_LEN(16'd1480)) dut (
      .aclk(aclk), .aresetn(aresetn), .data_in(data_in), .data_valid(data_valid),
      .ip_header_done(ip_header_done), .ip_header_valid(ip_header_valid),
      .udp_local_port(udp_local_port),
      .udp_src_port(udp_src_port), .udp_dst_port(udp_dst_port), .udp_len(udp_len),
      .udp_checksum(udp_checksum), .udp_header_done(udp_header_done),
      .payload_data(payload_data), .payload_valid(payload_valid),
      .payload_last(payload_last), .udp_error(udp_error)
   );

   udp_header_rx #(.PORT_CHECK_EN(0), .MAX_UDP_LEN(16'd1480)) dut_any (
      .aclk(aclk), .aresetn(aresetn), .data_in(data_in), .data_valid(data_valid),
      .ip_header_done(ip_header_done), .ip_header_valid(ip_header_valid),
      .udp_local_port(udp_local_port),
      .udp_src_port(a_src), .udp_dst_port(a_dst), .udp_len(a_len),
      .udp_checksum(a_cks), .udp_header_done(a_hd),
      .payload_data(a_pd), .payload_valid(a_pv),
      .payload_last(a_pl), .udp_error(a_err)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int errors = 0;
   int checks = 0;

   // Scoreboard of expected {payload_last, payload_data} for dut
   logic [8:0] sb[$];
   logic [7:0] fr[$];

   int hd_cnt = 0, err_cnt = 0, pv_cnt = 0, last_cnt = 0;
   int a_hd_cnt = 0, a_pv_cnt = 0;

   always @(negedge aclk) begin
      if (aresetn) begin
         if (udp_header_done) hd_cnt++;
         if (udp_error)       err_cnt++;
         if (payload_last)    last_cnt++;
         if (a_hd)            a_hd_cnt++;
         if (a_pv)            a_pv_cnt++;
         if (payload_valid) begin
            logic [8:0] e;
            pv_cnt++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got data=%02h last=%0b, required no payload", payload_data, payload_last);
            end else begin
               e = sb.pop_front();
               if ({payload_last, payload_data} !== e) begin
                  errors++;
                  $display("FAIL sb_payload: got data=%02h last=%0b, required data=%02h last=%0b",
                           payload_data, payload_last, e[7:0], e[8]);
               end
            end
         end
      end
   end

   function automatic logic [7:0] pay_byte(input int i);
      return 8'hAA + 8'(17 * i);
   endfunction

   task automatic build_frame(input logic [15:0] src, dst, len, cks, input int npay, input int pad);
      fr.delete();
      fr.push_back(src[15:8]); fr.push_back(src[7:0]);
      fr.push_back(dst[15:8]); fr.push_back(dst[7:0]);
      fr.push_back(len[15:8]); fr.push_back(len[7:0]);
      fr.push_back(cks[15:8]); fr.push_back(cks[7:0]);
      for (int i = 0; i < npay; i++) fr.push_back(pay_byte(i));
      for (int i = 0; i < pad; i++)  fr.push_back(8'($urandom));
   endtask

   // Expect the first min(npay, len-8) payload bytes; last on byte len-9
   task automatic push_exp(input logic [15:0] len, input int npay);
      int n;
      n = int'(len) - 8;
      for (int i = 0; i < npay && i < n; i++)
         sb.push_back({(i == n - 1), pay_byte(i)});
   endtask

   task automatic drive(input bit hv, input int gap);
      for (int i = 0; i < fr.size(); i++) begin
         @(posedge aclk); #1;
         data_in         = fr[i];
         data_valid      = 1'b1;
         ip_header_done  = (i == 0);
         ip_header_valid = (i == 1) && hv;
      end
      @(posedge aclk); #1;
      data_in = '0; data_valid = 1'b0; ip_header_done = 1'b0; ip_header_valid = 1'b0;
      repeat (gap - 1) @(posedge aclk);
      if (gap > 1) #1;
   endtask

   task automatic settle;
      repeat (2) @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic [15:0] src, dst, len, cks, input int npay, input int pad,
                       input bit hv, input bit exp_fwd, input int gap);
      build_frame(src, dst, len, cks, npay, pad);
      if (exp_fwd) push_exp(len, npay);
      drive(hv, gap);
   endtask

   task automatic test_reset;
      aresetn = 1'b0;
      data_in = '0; data_valid = 1'b0; ip_header_done = 1'b0; ip_header_valid = 1'b0;
      udp_local_port = 16'h04D2;
      repeat (2) @(posedge aclk);
      #1;
      checks++;
      if ({udp_src_port, udp_dst_port, udp_len, udp_checksum, udp_header_done,
           payload_data, payload_valid, payload_last, udp_error} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got src=%h dst=%h len=%h pv=%b err=%b, required all zero",
                  udp_src_port, udp_dst_port, udp_len, payload_valid, udp_error);
      end
      aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
   endtask

   task automatic test_valid;
      int hd0, er0, pv0, ls0;
      hd0 = hd_cnt; er0 = err_cnt; pv0 = pv_cnt; ls0 = last_cnt;
      send(16'h1F90, 16'h04D2, 16'h000C, 16'h1234, 4, 0, 1'b1, 1'b1, 3);
      settle();
      checks++;
      if (hd_cnt - hd0 !== 1) begin errors++; $display("FAIL valid_hdr_done: got %0d, required 1", hd_cnt - hd0); end
      checks++;
      if (pv_cnt - pv0 !== 4) begin errors++; $display("FAIL valid_pv_count: got %0d, required 4", pv_cnt - pv0); end
      checks++;
      if (last_cnt - ls0 !== 1) begin errors++; $display("FAIL valid_last_count: got %0d, required 1", last_cnt - ls0); end
      checks++;
      if (err_cnt - er0 !== 0) begin errors++; $display("FAIL valid_no_error: got %0d, required 0", err_cnt - er0); end
      checks++;
      if ({udp_src_port, udp_dst_port, udp_len, udp_checksum} !== {16'h1F90, 16'h04D2, 16'h000C, 16'h1234}) begin
         errors++;
         $display("FAIL valid_fields: got %h %h %h %h, required 1f90 04d2 000c 1234",
                  udp_src_port, udp_dst_port, udp_len, udp_checksum);
      end
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL valid_sb_empty: got %0d left, required 0", sb.size()); end
   endtask

   // Padding discarded; next frame starts the cycle after data_valid falls
   task automatic test_back_to_back;
      int hd0, pv0;
      hd0 = hd_cnt; pv0 = pv_cnt;
      send(16'h1F90, 16'h04D2, 16'h000C, 16'h0001, 4, 18, 1'b1, 1'b1, 1);
      send(16'h2000, 16'h04D2, 16'h000B, 16'h0002, 3, 0, 1'b1, 1'b1, 3);
      settle();
      checks++;
      if (pv_cnt - pv0 !== 7) begin errors++; $display("FAIL b2b_pv_count: got %0d, required 7", pv_cnt - pv0); end
      checks++;
      if (hd_cnt - hd0 !== 2) begin errors++; $display("FAIL b2b_hdr_done: got %0d, required 2", hd_cnt - hd0); end
      checks++;
      if (udp_src_port !== 16'h2000) begin errors++; $display("FAIL b2b_src: got %h, required 2000", udp_src_port); end
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL b2b_sb_empty: got %0d left, required 0", sb.size()); end
   endtask

   task automatic test_port_filter;
      int hd0, er0, pv0, ahd0, apv0;
      hd0 = hd_cnt; er0 = err_cnt; pv0 = pv_cnt; ahd0 = a_hd_cnt; apv0 = a_pv_cnt;
      send(16'h1F90, 16'h0035, 16'h000C, 16'h0000, 4, 2, 1'b1, 1'b0, 3);
      settle();
      checks++;
      if ({hd_cnt - hd0, err_cnt - er0, pv_cnt - pv0} !== {32'd0, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL port_drop: got hd=%0d err=%0d pv=%0d, required 0 0 0",
                  hd_cnt - hd0, err_cnt - er0, pv_cnt - pv0);
      end
      checks++;
      if (a_pv_cnt - apv0 !== 4 || a_hd_cnt - ahd0 !== 1) begin
         errors++;
         $display("FAIL port_any_fwd: got pv=%0d hd=%0d, required pv=4 hd=1", a_pv_cnt - apv0, a_hd_cnt - ahd0);
      end
   endtask

   task automatic test_no_ip_valid;
      int hd0, er0, pv0;
      hd0 = hd_cnt; er0 = err_cnt; pv0 = pv_cnt;
      send(16'h1F90, 16'h04D2, 16'h000C, 16'h0000, 4, 0, 1'b0, 1'b0, 3);
      settle();
      checks++;
      if ({hd_cnt - hd0, err_cnt - er0, pv_cnt - pv0} !== {32'd0, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL noip_quiet: got hd=%0d err=%0d pv=%0d, required 0 0 0",
                  hd_cnt - hd0, err_cnt - er0, pv_cnt - pv0);
      end
      send(16'h1F91, 16'h04D2, 16'h000A, 16'h0000, 2, 0, 1'b1, 1'b1, 3);
      settle();
      checks++;
      if (hd_cnt - hd0 !== 1 || pv_cnt - pv0 !== 2) begin
         errors++;
         $display("FAIL noip_recover: got hd=%0d pv=%0d, required hd=1 pv=2", hd_cnt - hd0, pv_cnt - pv0);
      end
   endtask

   task automatic test_length;
      int hd0, er0, pv0;
      hd0 = hd_cnt; er0 = err_cnt; pv0 = pv_cnt;
      send(16'h1111, 16'h04D2, 16'h0004, 16'h0000, 4, 0, 1'b1, 1'b0, 3);
      settle();
      checks++;
      if (err_cnt - er0 !== 1 || pv_cnt - pv0 !== 0 || hd_cnt - hd0 !== 0) begin
         errors++;
         $display("FAIL len_short: got err=%0d pv=%0d hd=%0d, required 1 0 0", err_cnt - er0, pv_cnt - pv0, hd_cnt - hd0);
      end
      er0 = err_cnt;
      send(16'h1111, 16'h04D2, 16'h05DD, 16'h0000, 6, 0, 1'b1, 1'b0, 3);
      settle();
      checks++;
      if (err_cnt - er0 !== 1 || pv_cnt - pv0 !== 0 || hd_cnt - hd0 !== 0) begin
         errors++;
         $display("FAIL len_long: got err=%0d pv=%0d hd=%0d, required 1 0 0", err_cnt - er0, pv_cnt - pv0, hd_cnt - hd0);
      end
      er0 = err_cnt;
      send(16'h1111, 16'h04D2, 16'h0008, 16'h0000, 0, 4, 1'b1, 1'b0, 3);
      settle();
      checks++;
      if (hd_cnt - hd0 !== 1 || pv_cnt - pv0 !== 0 || err_cnt - er0 !== 0) begin
         errors++;
         $display("FAIL len_eight: got hd=%0d pv=%0d err=%0d, required 1 0 0", hd_cnt - hd0, pv_cnt - pv0, err_cnt - er0);
      end
      hd0 = hd_cnt; pv0 = pv_cnt;
      send(16'h1111, 16'h04D2, 16'd1480, 16'h0000, 1472, 2, 1'b1, 1'b1, 3);
      settle();
      checks++;
      if (hd_cnt - hd0 !== 1 || pv_cnt - pv0 !== 1472 || err_cnt - er0 !== 0) begin
         errors++;
         $display("FAIL len_max: got hd=%0d pv=%0d err=%0d, required 1 1472 0", hd_cnt - hd0, pv_cnt - pv0, err_cnt - er0);
      end
   endtask

   task automatic test_truncate;
      int hd0, er0, pv0, ls0;
      hd0 = hd_cnt; er0 = err_cnt; pv0 = pv_cnt; ls0 = last_cnt;
      send(16'h3333, 16'h04D2, 16'h000C, 16'h0000, 2, 0, 1'b1, 1'b1, 3);
      settle();
      checks++;
      if (pv_cnt - pv0 !== 2 || last_cnt - ls0 !== 0) begin
         errors++;
         $display("FAIL trunc_payload: got pv=%0d last=%0d, required pv=2 last=0", pv_cnt - pv0, last_cnt - ls0);
      end
      checks++;
      if (err_cnt - er0 !== 1 || hd_cnt - hd0 !== 1) begin
         errors++;
         $display("FAIL trunc_error: got err=%0d hd=%0d, required err=1 hd=1", err_cnt - er0, hd_cnt - hd0);
      end

      // Reset while the second payload byte sits on the outputs
      build_frame(16'h4444, 16'h04D2, 16'h000C, 16'h0000, 4, 0);
      sb.push_back({1'b0, pay_byte(0)});
      for (int i = 0; i < 10; i++) begin
         @(posedge aclk); #1;
         data_in = fr[i]; data_valid = 1'b1;
         ip_header_done = (i == 0); ip_header_valid = (i == 1);
      end
      @(posedge aclk); #2;
      checks++;
      if (payload_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_pv: got %b, required 1", payload_valid); end
      aresetn = 1'b0;
      #1;
      checks++;
      if ({udp_src_port, udp_dst_port, udp_len, udp_checksum, udp_header_done,
           payload_data, payload_valid, payload_last, udp_error} !== '0) begin
         errors++;
         $display("FAIL rst_mid_payload: got src=%h pd=%h pv=%b, required all zero",
                  udp_src_port, payload_data, payload_valid);
      end
      data_valid = 1'b0; ip_header_done = 1'b0; ip_header_valid = 1'b0; data_in = '0;
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      settle();
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL rst_sb_empty: got %0d left, required 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_valid();
      test_back_to_back();
      test_port_filter();
      test_no_ip_valid();
      test_length();
      test_truncate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule
